// File: rtl/gray_conv_pkg.sv
// Shared types and helpers for the pipelined binary/Gray converter.
// The optional statistics counters are enabled with the GRAY_CONV_STATS_EN macro.
package gray_conv_pkg;

    typedef enum logic {
        BIN2GRAY = 1'b0,
        GRAY2BIN = 1'b1
    } conv_mode_e;

    localparam int STAT_W = 16;

    // Lowest bit index resolved by stage k of the Gray->binary chain.
    // The result is clipped at 0, so the final stages may end up with an empty chunk.
    function automatic int chunk_lsb(input int k, input int width, input int stages);
        int chunk;
        int lsb;
        chunk = (width + stages - 1) / stages;
        lsb   = width - (k + 1) * chunk;
        return (lsb < 0) ? 0 : lsb;
    endfunction

endpackage

// File: rtl/gray_conv_stage.sv
// One elastic register slice of the binary/Gray converter.
// Stage 0 performs the complete binary->Gray conversion. Every stage resolves its own
// chunk of the Gray->binary prefix-XOR, starting from the carry supplied by the stage above.
module gray_conv_stage
    import gray_conv_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int IDX    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry
);

    localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;
    // The MSB can be negative for trailing stages. Those stages then have no bits to resolve.
    localparam int MSB   = WIDTH - 1 - IDX * CHUNK;
    localparam int LSB   = chunk_lsb(IDX, WIDTH, STAGES);

    logic             valid_q;
    logic             mode_q;
    logic             carry_q;
    logic [WIDTH-1:0] data_q;

    logic [WIDTH-1:0] data_nxt;
    logic             carry_nxt;
    logic             c;

    // Resolve this stage's share of the conversion for the beat being presented.
    always_comb begin
        data_nxt  = in_data;
        carry_nxt = in_carry;
        c         = in_carry;
        if (conv_mode_e'(in_mode) == GRAY2BIN) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (i <= MSB && i >= LSB) begin
                    data_nxt[i] = c ^ in_data[i];
                    c           = data_nxt[i];
                end
            end
            carry_nxt = c;
        end else if (IDX == 0) begin
            data_nxt = in_data ^ (in_data >> 1);
        end
    end

    // Slice register: load on handshake, empty when downstream takes the beat.
    // Data is only written on an accepted beat, so idle input values never reach the pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
            carry_q <= 1'b0;
            data_q  <= '0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            mode_q  <= in_mode;
            carry_q <= carry_nxt;
            data_q  <= data_nxt;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_mode  = mode_q;
    assign out_data  = data_q;
    assign out_carry = carry_q;

endmodule

// File: rtl/gray_conv_pipe.sv
// Pipelined, elastic binary<->Gray converter. The direction is selected per beat by in_mode.
// Defining GRAY_CONV_STATS_EN adds saturating delivered-beat counters, one per mode.
module gray_conv_pipe
    import gray_conv_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mode,
`ifdef GRAY_CONV_STATS_EN
    output logic [WIDTH-1:0]  out_data,
    output logic [STAT_W-1:0] cnt_b2g,
    output logic [STAT_W-1:0] cnt_g2b
`else
    output logic [WIDTH-1:0]  out_data
`endif
);

    // Index k of each chain is the input of stage k. Index STAGES is the pipe output.
    logic             v_ch [STAGES+1];
    logic             r_ch [STAGES+1];
    logic             m_ch [STAGES+1];
    logic             c_ch [STAGES+1];
    logic [WIDTH-1:0] d_ch [STAGES+1];

    assign v_ch[0]      = in_valid;
    assign m_ch[0]      = in_mode;
    assign d_ch[0]      = in_data;
    assign c_ch[0]      = 1'b0;
    assign in_ready     = r_ch[0];
    assign r_ch[STAGES] = out_ready;
    assign out_valid    = v_ch[STAGES];
    assign out_mode     = m_ch[STAGES];
    assign out_data     = d_ch[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        gray_conv_stage #(
            .WIDTH (WIDTH),
            .STAGES(STAGES),
            .IDX   (k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (v_ch[k]),
            .in_ready (r_ch[k]),
            .in_mode  (m_ch[k]),
            .in_data  (d_ch[k]),
            .in_carry (c_ch[k]),
            .out_valid(v_ch[k+1]),
            .out_ready(r_ch[k+1]),
            .out_mode (m_ch[k+1]),
            .out_data (d_ch[k+1]),
            .out_carry(c_ch[k+1])
        );
    end

`ifdef GRAY_CONV_STATS_EN
    // Count delivered beats per mode. Each counter sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_b2g <= '0;
            cnt_g2b <= '0;
        end else if (out_valid && out_ready) begin
            if (conv_mode_e'(out_mode) == GRAY2BIN) begin
                if (cnt_g2b != '1) cnt_g2b <= cnt_g2b + STAT_W'(1);
            end else begin
                if (cnt_b2g != '1) cnt_b2g <= cnt_b2g + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Scoreboard bench for gray_conv_pipe.
// Instance A uses WIDTH=8, STAGES=2 and gets directed, stall, reset and random traffic.
// Instance B uses WIDTH=5, STAGES=5 and gets the exhaustive sweep.
module tb_gray_conv_pipe;

    typedef struct {
        logic       mode;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode;
    logic [7:0] a_in_data, a_out_data;
    logic       b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode;
    logic [4:0] b_in_data, b_out_data;
`ifdef GRAY_CONV_STATS_EN
    logic [15:0] a_cnt_b2g, a_cnt_g2b, b_cnt_b2g, b_cnt_g2b;
`endif

    gray_conv_pipe #(.WIDTH(8), .STAGES(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_mode(a_out_mode),
`ifdef GRAY_CONV_STATS_EN
        .cnt_b2g(a_cnt_b2g), .cnt_g2b(a_cnt_g2b),
`endif
        .out_data(a_out_data)
    );

    gray_conv_pipe #(.WIDTH(5), .STAGES(5)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_mode(b_out_mode),
`ifdef GRAY_CONV_STATS_EN
        .cnt_b2g(b_cnt_b2g), .cnt_g2b(b_cnt_g2b),
`endif
        .out_data(b_out_data)
    );

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   a_acc_cyc = 0;
    bit   done = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: Gray is b ^ (b >> 1). Binary is the XOR of all right shifts of g.
    function automatic logic [7:0] ref_conv(input logic mode, input logic [7:0] v, input int w);
        logic [7:0] mask;
        logic [7:0] r;
        mask = 8'((1 << w) - 1);
        v    = v & mask;
        if (!mode) return (v ^ (v >> 1)) & mask;
        r = '0;
        for (int s = 0; s < w; s++) r ^= v >> s;
        return r & mask;
    endfunction

    // Monitors: compare every delivered beat against the head of its queue.
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) chk("a_unexpected_beat", 32'(a_out_valid), 32'd0);
            else begin
                ea = qa.pop_front();
                chk("a_data", 32'(a_out_data), 32'(ea.data));
                chk("a_mode", 32'(a_out_mode), 32'(ea.mode));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) chk("b_unexpected_beat", 32'(b_out_valid), 32'd0);
            else begin
                eb = qb.pop_front();
                chk("b_data", 32'(b_out_data), 32'(eb.data));
                chk("b_mode", 32'(b_out_mode), 32'(eb.mode));
            end
        end
    end

    task automatic send_a(input logic m, input logic [7:0] d, input logic [7:0] e);
        int n = 0;
        a_in_valid = 1'b1; a_in_mode = m; a_in_data = d;
        @(negedge clk);
        while (!a_in_ready && n < 500) begin n++; @(negedge clk); end
        if (!a_in_ready) chk("a_send_timeout", 32'(a_in_ready), 32'd1);
        else begin qa.push_back('{m, e}); a_acc_cyc = cyc; end
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_in_mode = 1'($urandom); a_in_data = 8'($urandom);
    endtask

    task automatic send_b(input logic m, input logic [4:0] d);
        int n = 0;
        b_in_valid = 1'b1; b_in_mode = m; b_in_data = d;
        @(negedge clk);
        while (!b_in_ready && n < 500) begin n++; @(negedge clk); end
        if (!b_in_ready) chk("b_send_timeout", 32'(b_in_ready), 32'd1);
        else qb.push_back('{m, ref_conv(m, 8'(d), 5)});
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_in_mode = 1'($urandom); b_in_data = 5'($urandom);
    endtask

    task automatic drain_a();
        int n = 0;
        while (qa.size() != 0 && n < 2000) begin n++; @(negedge clk); end
        chk("a_drain", 32'(qa.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic drain_b();
        int n = 0;
        while (qb.size() != 0 && n < 2000) begin n++; @(negedge clk); end
        chk("b_drain", 32'(qb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int         n, run_len, idx, ovs;
        logic [7:0] held;
        logic       sm [3];
        logic [7:0] sd [3];
        logic [7:0] se [3];

        rst_n = 1'b0;
        a_in_valid = 0; a_in_mode = 0; a_in_data = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_mode = 0; b_in_data = 0; b_out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_data", 32'(a_out_data), 32'd0);
        chk("rst_out_mode", 32'(a_out_mode), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        @(posedge clk); #1;

        // Latency: a single beat into an empty pipe appears exactly STAGES cycles later.
        send_a(1'b0, 8'h5A, 8'h77);
        n = 0;
        do begin @(negedge clk); n++; end while (!a_out_valid && n < 20);
        chk("a_latency", 32'(cyc - a_acc_cyc), 32'd2);
        @(posedge clk); #1;

        send_a(1'b1, 8'h77, 8'h5A);
        send_a(1'b1, 8'h80, 8'hFF);
        send_a(1'b0, 8'hFF, 8'h80);
        drain_a();

        // Back-to-back beats with alternating modes must come out in one unbroken run.
        run_len = 0;
        fork
            begin
                send_a(1'b0, 8'h12, ref_conv(1'b0, 8'h12, 8));
                send_a(1'b1, 8'h3C, ref_conv(1'b1, 8'h3C, 8));
                send_a(1'b0, 8'hA5, ref_conv(1'b0, 8'hA5, 8));
                send_a(1'b1, 8'hC3, ref_conv(1'b1, 8'hC3, 8));
            end
            begin
                int m = 0;
                while (!a_out_valid && m < 50) begin @(negedge clk); m++; end
                while (a_out_valid && m < 50) begin run_len++; @(negedge clk); m++; end
            end
        join
        chk("a_b2b_run", 32'(run_len), 32'd4);
        drain_a();

        // Stall: hold out_ready low for 5 cycles and offer 3 beats.
        sm = '{1'b0, 1'b1, 1'b0}; sd = '{8'h21, 8'h9E, 8'h44};
        for (int i = 0; i < 3; i++) se[i] = ref_conv(sm[i], sd[i], 8);
        a_out_ready = 1'b0;
        idx = 0; held = '0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 3) begin a_in_valid = 1; a_in_mode = sm[idx]; a_in_data = sd[idx]; end
            @(negedge clk);
            if (c == 2) begin
                held = a_out_data;
                chk("a_stall_in_ready", 32'(a_in_ready), 32'd0);
                chk("a_stall_out_valid", 32'(a_out_valid), 32'd1);
                chk("a_stall_head", 32'(held), 32'(se[0]));
            end
            if (c > 2) chk("a_stall_stable", 32'(a_out_data), 32'(held));
            if (a_in_valid && a_in_ready) begin qa.push_back('{sm[idx], se[idx]}); idx++; end
            @(posedge clk); #1;
        end
        chk("a_stall_accepted", 32'(idx), 32'd2);
        a_out_ready = 1'b1;
        a_in_valid = 1'b0;
        if (idx < 3) send_a(sm[idx], sd[idx], se[idx]);
        drain_a();

        // Reset with two beats in flight must discard both of them.
        a_out_ready = 1'b0;
        send_a(1'b0, 8'h0F, 8'h08);
        send_a(1'b1, 8'hF0, 8'hA0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        qa.delete();
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("a_flush_out_valid", 32'(a_out_valid), 32'd0);
        chk("a_flush_in_ready", 32'(a_in_ready), 32'd1);
        ovs = 0;
        repeat (6) begin @(negedge clk); if (a_out_valid) ovs++; end
        chk("a_flush_no_stale", 32'(ovs), 32'd0);
        @(posedge clk); #1;

        // Random traffic with random backpressure.
        done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic       m;
                    logic [7:0] d;
                    m = 1'($urandom);
                    d = 8'($urandom);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1 send_a(m, d, ref_conv(m, d, 8));
                end
                done = 1;
            end
            begin
                while (!done) begin @(posedge clk); #1 a_out_ready = ($urandom_range(0, 3) != 0); end
            end
        join
        a_out_ready = 1'b1;
        drain_a();

        // Exhaustive sweep on WIDTH=5, STAGES=5 with random backpressure.
        done = 0;
        fork
            begin
                for (int m = 0; m < 2; m++)
                    for (int v = 0; v < 32; v++) send_b(1'(m), 5'(v));
                done = 1;
            end
            begin
                while (!done) begin @(posedge clk); #1 b_out_ready = ($urandom_range(0, 2) != 0); end
            end
        join
        b_out_ready = 1'b1;
        drain_b();
`ifdef GRAY_CONV_STATS_EN
        repeat (2) @(posedge clk);
        #1;
        chk("b_cnt_b2g", 32'(b_cnt_b2g), 32'd32);
        chk("b_cnt_g2b", 32'(b_cnt_g2b), 32'd32);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
